// File: rtl/arb_pkg.sv
// Shared encodings for the IF/LS memory bus arbiter and its watchdog.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/arb_wdog.sv
// Transaction watchdog: counts cycles spent in ADDR+DATA, flags the last allowed cycle.
module arb_wdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   // Saturates so a late address grant still leaves the data phase bounded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && cnt != LAST) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-outstanding memory port between IF and LS, LS has fixed priority.
// Optional transaction timeout with err_o is built when ARB_TIMEOUT_EN is defined.
//
//   state | meaning
//   IDLE  | no transaction; turnaround cycle, owner picked from requests
//   ADDR  | address phase, mem_req_o high, waiting for mem_gnt_i
//   DATA  | address accepted, waiting for mem_rvalid_i
module mem_bus_arbiter
   import arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req_i,
   input  logic [AW-1:0]   if_addr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [DW-1:0]   if_rdata_o,
   input  logic            ls_req_i,
   input  logic            ls_we_i,
   input  logic [DW/8-1:0] ls_be_i,
   input  logic [AW-1:0]   ls_addr_i,
   input  logic [DW-1:0]   ls_wdata_i,
   output logic            ls_gnt_o,
   output logic            ls_rvalid_o,
   output logic [DW-1:0]   ls_rdata_o,
   input  logic            flush_i,
   output logic            hold_flag_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [DW/8-1:0] mem_be_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [DW-1:0]   mem_rdata_i
`ifdef ARB_TIMEOUT_EN
   ,
   output logic            err_o
`endif
);

   state_t        state, state_nxt;
   owner_t        owner, owner_nxt;
   logic          drop, drop_nxt;
   logic          is_ls;
   logic          timeout;
   logic          resp;
   logic [DW-1:0] resp_data;

   assign is_ls = (owner == OWN_LS);

`ifdef ARB_TIMEOUT_EN
   logic expired;

   arb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == IDLE && (if_req_i || ls_req_i)),
      .en      (state != IDLE),
      .expired (expired)
   );

   // A handshake landing on the last allowed cycle takes precedence.
   assign timeout = expired && !((state == ADDR) ? mem_gnt_i : mem_rvalid_i);
   assign err_o   = timeout;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign timeout        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         owner <= OWN_IF;
         drop  <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         drop  <= drop_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      drop_nxt    = drop;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if_gnt_o    = 1'b0;
      ls_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      ls_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      ls_rdata_o  = '0;
      resp        = 1'b0;
      resp_data   = mem_rdata_i;

      unique case (state)
         IDLE: begin
            if (ls_req_i || if_req_i) begin
               state_nxt = ADDR;
               owner_nxt = ls_req_i ? OWN_LS : OWN_IF;
            end
         end
         ADDR: begin
            mem_req_o = 1'b1;
            if (is_ls) begin
               mem_we_o    = ls_we_i;
               mem_be_o    = ls_be_i;
               mem_addr_o  = ls_addr_i;
               mem_wdata_o = ls_wdata_i;
            end else begin
               mem_be_o   = '1;
               mem_addr_o = if_addr_i;
            end
            if (mem_gnt_i) begin
               state_nxt = DATA;
               if_gnt_o  = !is_ls;
               ls_gnt_o  = is_ls;
            end
         end
         DATA: begin
            if (mem_rvalid_i) begin
               resp      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (timeout) begin
         resp      = 1'b1;
         resp_data = is_ls ? '0 : DW'(NOP_INSN);
         state_nxt = IDLE;
      end

      if (state != IDLE && !is_ls && flush_i) begin
         drop_nxt = 1'b1;
      end

      // A flushed fetch still completes on the bus but never reaches the pipeline.
      if (resp) begin
         if (is_ls) begin
            ls_rvalid_o = 1'b1;
            ls_rdata_o  = resp_data;
         end else if (!drop && !flush_i) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = resp_data;
         end
      end

      if (state_nxt == IDLE) begin
         drop_nxt = 1'b0;
      end
   end

   assign hold_flag_o = rst & ((ls_req_i & ~ls_gnt_o) |
                               ((state == DATA) & is_ls & ~mem_rvalid_i));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level model and memory slave.
// Define ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_mem_bus_arbiter;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_gnt_o, if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        ls_req_i = 1'b0, ls_we_i = 1'b0;
   logic [3:0]  ls_be_i = '0;
   logic [31:0] ls_addr_i = '0, ls_wdata_i = '0;
   logic        ls_gnt_o, ls_rvalid_o;
   logic [31:0] ls_rdata_o;
   logic        flush_i = 1'b0;
   logic        hold_flag_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
`ifdef ARB_TIMEOUT_EN
   logic        err_o;
`endif

   always #5 clk = ~clk;

   mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .if_gnt_o     (if_gnt_o),
      .if_rvalid_o  (if_rvalid_o),
      .if_rdata_o   (if_rdata_o),
      .ls_req_i     (ls_req_i),
      .ls_we_i      (ls_we_i),
      .ls_be_i      (ls_be_i),
      .ls_addr_i    (ls_addr_i),
      .ls_wdata_i   (ls_wdata_i),
      .ls_gnt_o     (ls_gnt_o),
      .ls_rvalid_o  (ls_rvalid_o),
      .ls_rdata_o   (ls_rdata_o),
      .flush_i      (flush_i),
      .hold_flag_o  (hold_flag_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
`ifdef ARB_TIMEOUT_EN
      ,
      .err_o        (err_o)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // stimulus knobs (percent)
   int  p_if = 0, p_ls = 0, p_gnt = 0, p_rv = 0, p_fl = 0;
   bit  no_force = 0, force_flush = 0, rst_val = 0;

   // requesters
   bit          if_pend = 0, ls_pend = 0;
   logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
   logic        ls_we = 1'b0;
   logic [3:0]  ls_be = '0;

   // transaction model
   bit          cur_valid = 0, cur_ls = 0, cur_acc = 0, cur_drop = 0;
   logic [31:0] cur_addr = '0, cur_wdata = '0;
   logic        cur_we = 1'b0;
   logic [3:0]  cur_be = '0;
   int          cur_cnt = 0;

   // memory slave
   logic [31:0] mem_arr [16];
   bit          sl_pend = 0;
   logic [31:0] sl_addr = '0, sl_wdata = '0;
   logic        sl_we = 1'b0;
   logic [3:0]  sl_be = '0;
   int          sl_wait = 0, gnt_wait = 0;

   int n_if_rv = 0, n_err = 0;

   task automatic drive();
      rst = rst_val;
      if (!if_pend && $urandom_range(99) < p_if) begin
         if_pend = 1;
         if_addr = 32'($urandom_range(255)) << 2;
      end
      if (!ls_pend && $urandom_range(99) < p_ls) begin
         ls_pend  = 1;
         ls_addr  = 32'($urandom_range(255)) << 2;
         ls_we    = 1'($urandom_range(1));
         ls_be    = 4'($urandom_range(15, 1));
         ls_wdata = $urandom;
      end
      if_req_i     = if_pend;
      if_addr_i    = if_addr;
      ls_req_i     = ls_pend;
      ls_addr_i    = ls_addr;
      ls_we_i      = ls_we;
      ls_be_i      = ls_be;
      ls_wdata_i   = ls_wdata;
      mem_gnt_i    = ($urandom_range(99) < p_gnt) || (!no_force && gnt_wait >= 5);
      mem_rvalid_i = sl_pend && (($urandom_range(99) < p_rv) || (!no_force && sl_wait >= 5));
      mem_rdata_i  = mem_rvalid_i ? mem_arr[sl_addr[5:2]] : $urandom;
      flush_i      = force_flush || ($urandom_range(99) < p_fl);
      force_flush  = 0;
   endtask

   // One clock: drive after the edge, check and advance the model at the falling edge.
   task automatic step();
      logic        e_req, e_we, e_ifg, e_lsg, e_ifv, e_lsv, e_hold, e_err;
      logic [3:0]  e_be;
      logic [31:0] e_addr, e_wd, e_ifd, e_lsd, resp_d;
      bit          fire, resp;
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      {e_req, e_we, e_ifg, e_lsg, e_ifv, e_lsv, e_hold, e_err} = '0;
      e_be = '0; e_addr = '0; e_wd = '0; e_ifd = '0; e_lsd = '0;
      fire = 0; resp = 0; resp_d = '0;
      if (rst) begin
         e_hold = ls_req_i;
         if (cur_valid) begin
`ifdef ARB_TIMEOUT_EN
            fire = (cur_cnt >= TIMEOUT - 1) && !(cur_acc ? mem_rvalid_i : mem_gnt_i);
`endif
            resp   = fire || (cur_acc && mem_rvalid_i);
            resp_d = fire ? (cur_ls ? 32'h0 : 32'h0000_0013) : mem_arr[cur_addr[5:2]];
            if (!cur_acc) begin
               e_req = 1; e_we = cur_we; e_be = cur_be; e_addr = cur_addr; e_wd = cur_wdata;
               if (mem_gnt_i) begin
                  e_ifg = !cur_ls;
                  e_lsg = cur_ls;
               end
            end
            if (resp) begin
               if (cur_ls) begin
                  e_lsv = 1; e_lsd = resp_d;
               end else if (!cur_drop && !flush_i) begin
                  e_ifv = 1; e_ifd = resp_d;
               end
            end
            e_hold = (ls_req_i && !e_lsg) || (cur_ls && cur_acc && !mem_rvalid_i);
            e_err  = fire;
         end
      end
      check("mem_req",   64'(mem_req_o),   64'(e_req));
      check("mem_we",    64'(mem_we_o),    64'(e_we));
      check("mem_be",    64'(mem_be_o),    64'(e_be));
      check("mem_addr",  64'(mem_addr_o),  64'(e_addr));
      check("mem_wdata", 64'(mem_wdata_o), 64'(e_wd));
      check("if_gnt",    64'(if_gnt_o),    64'(e_ifg));
      check("ls_gnt",    64'(ls_gnt_o),    64'(e_lsg));
      check("if_rvalid", 64'(if_rvalid_o), 64'(e_ifv));
      check("ls_rvalid", 64'(ls_rvalid_o), 64'(e_lsv));
      check("if_rdata",  64'(if_rdata_o),  64'(e_ifd));
      check("ls_rdata",  64'(ls_rdata_o),  64'(e_lsd));
      check("hold_flag", 64'(hold_flag_o), 64'(e_hold));
`ifdef ARB_TIMEOUT_EN
      check("err", 64'(err_o), 64'(e_err));
      if (err_o) n_err++;
`endif
      if (if_rvalid_o) n_if_rv++;

      if (!rst) begin
         cur_valid = 0; sl_pend = 0; sl_wait = 0; gnt_wait = 0;
      end else begin
         if (!cur_valid) begin
            if (if_req_i || ls_req_i) begin
               cur_valid = 1; cur_ls = ls_req_i; cur_acc = 0; cur_drop = 0; cur_cnt = 0;
               cur_addr  = ls_req_i ? ls_addr_i  : if_addr_i;
               cur_we    = ls_req_i ? ls_we_i    : 1'b0;
               cur_be    = ls_req_i ? ls_be_i    : 4'hF;
               cur_wdata = ls_req_i ? ls_wdata_i : 32'h0;
            end
         end else begin
            if (flush_i && !cur_ls) cur_drop = 1;
            if (resp) cur_valid = 0;
            else if (!cur_acc && mem_gnt_i) cur_acc = 1;
            cur_cnt++;
         end
         if (if_gnt_o) if_pend = 0;
         if (ls_gnt_o) ls_pend = 0;
         if (sl_pend && mem_rvalid_i) begin
            if (sl_we)
               for (int b = 0; b < 4; b++)
                  if (sl_be[b]) mem_arr[sl_addr[5:2]][8*b +: 8] = sl_wdata[8*b +: 8];
            sl_pend = 0; sl_wait = 0;
         end else if (sl_pend) begin
            sl_wait++;
         end
         if (mem_req_o && mem_gnt_i) begin
            sl_pend = 1; sl_addr = mem_addr_o; sl_we = mem_we_o; sl_be = mem_be_o;
            sl_wdata = mem_wdata_o; gnt_wait = 0;
         end else if (mem_req_o) begin
            gnt_wait++;
         end else begin
            gnt_wait = 0;
         end
      end
   endtask

   initial begin
      int gc, rc, lgc, lrc, cnt_stable, cnt_hold, rv_before;
      bit did_rst;
      for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;

      repeat (3) step();
      rst_val = 1;

      // zero-wait IF read
      p_gnt = 100; p_rv = 100;
      if_pend = 1; if_addr = 32'h100;
      gc = -1; rc = -1;
      for (int c = 0; c < 20 && rc < 0; c++) begin
         step();
         if (if_gnt_o && gc < 0) gc = c;
         if (if_rvalid_o) rc = c;
      end
      check("if_gnt_cycle",    64'(gc), 64'(1));
      check("if_rvalid_cycle", 64'(rc), 64'(2));

      // contention: LS write first, IF after one turnaround
      if_pend = 1; if_addr = 32'h40;
      ls_pend = 1; ls_we = 1; ls_be = 4'hF; ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF;
      gc = -1; rc = -1; lgc = -1; lrc = -1;
      for (int c = 0; c < 30 && rc < 0; c++) begin
         step();
         if (ls_gnt_o) lgc = c;
         if (ls_rvalid_o) lrc = c;
         if (if_gnt_o) gc = c;
         if (if_rvalid_o) rc = c;
      end
      check("ls_gnt_cycle",    64'(lgc), 64'(1));
      check("ls_rvalid_cycle", 64'(lrc), 64'(2));
      check("if_gnt_after_ls", 64'(gc),  64'(4));
      check("ls_write_data",   64'(mem_arr[0]), 64'(32'hDEAD_BEEF));

      // flush while IF in DATA
      p_rv = 0;
      if_pend = 1; if_addr = 32'h80;
      gc = -1;
      for (int c = 0; c < 20 && gc < 0; c++) begin
         step();
         if (if_gnt_o) gc = c;
      end
      check("flush_if_gnt", 64'(gc), 64'(1));
      rv_before = n_if_rv;
      force_flush = 1;
      step();
      step();
      p_rv = 100;
      step();
      check("flush_mem_rvalid", 64'(mem_rvalid_i), 64'(1));
      step();
      check("flush_if_rvalid_count", 64'(n_if_rv - rv_before), 64'(0));

      // LS byte read with 3 address wait states
      p_gnt = 0;
      ls_pend = 1; ls_we = 0; ls_be = 4'b0010; ls_addr = 32'h24; ls_wdata = 32'h0;
      cnt_stable = 0; cnt_hold = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (hold_flag_o) cnt_hold++;
         if (mem_req_o && mem_addr_o == 32'h24 && mem_be_o == 4'b0010 && !mem_we_o) cnt_stable++;
      end
      p_gnt = 100;
      step();
      if (mem_req_o && mem_addr_o == 32'h24 && mem_be_o == 4'b0010 && !mem_we_o) cnt_stable++;
      check("wait_fields_stable", 64'(cnt_stable), 64'(4));
      check("wait_hold_cycles",   64'(cnt_hold),   64'(4));
      lrc = -1;
      for (int c = 0; c < 20 && lrc < 0; c++) begin
         step();
         if (ls_rvalid_o) lrc = c;
      end
      check("wait_ls_rvalid", 64'(lrc), 64'(0));

`ifdef ARB_TIMEOUT_EN
      step();
      p_gnt = 0; no_force = 1;
      if_pend = 1; if_addr = 32'h10;
      rc = -1;
      for (int c = 0; c < 40 && rc < 0; c++) begin
         step();
         if (err_o) begin
            rc = c;
            check("timeout_if_rvalid", 64'(if_rvalid_o), 64'(1));
            check("timeout_if_rdata",  64'(if_rdata_o),  64'(32'h0000_0013));
         end
      end
      check("timeout_cycle", 64'(rc), 64'(16));
      p_gnt = 100; no_force = 0;
      gc = -1;
      for (int c = 0; c < 20 && gc < 0; c++) begin
         step();
         if (if_gnt_o) gc = c;
      end
      check("timeout_retry_gnt", 64'(gc >= 0), 64'(1));
`endif

      // random traffic with a reset dropped into an outstanding transaction
      p_if = 40; p_ls = 40; p_gnt = 60; p_rv = 60; p_fl = 10;
      did_rst = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i > 1500 && !did_rst && cur_valid && cur_acc) begin
            did_rst = 1;
            rst_val = 0;
            step();
            step();
            rst_val = 1;
         end
         step();
      end
      check("random_reset_hit", 64'(did_rst), 64'(1));
`ifdef ARB_TIMEOUT_EN
      check("timeout_pulses", 64'(n_err), 64'(1));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
